// File: rtl/pc_ras.sv
// pc_ras: program-counter unit with a hardware return-address stack.
//
// Selects the next PC each enabled cycle. It can step sequentially, take a
// signed relative branch, take an absolute jump, call a subroutine (push the
// return address, then jump) or return from one (pop into PC). The return
// address stack is a circular buffer. When a call arrives with the stack full,
// the oldest entry is overwritten, so the most recent DEPTH return addresses
// are always available.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   en         update enable; when 0 every piece of state is frozen
//   PC_sel     next-PC mode: INC, HOLD, BRANCH, JUMP, CALL, RET (110/111 act as INC)
//   PC_in      absolute target for JUMP / CALL
//   PC_branch  signed two's-complement offset for BRANCH
//   err_clr    clears the sticky error flags (a set in the same cycle wins)
//   PC_out     current PC (registered)
//   ras_count  number of valid stack entries, 0..DEPTH
//   ras_empty  ras_count == 0
//   ras_full   ras_count == DEPTH
//   ras_ovf    sticky: a CALL was issued while the stack was full
//   ras_unf    sticky: a RET was issued while the stack was empty
module pc_ras #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      STEP      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [2:0]               PC_sel,
    input  logic [WIDTH-1:0]         PC_in,
    input  logic [WIDTH-1:0]         PC_branch,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         PC_out,
    output logic [$clog2(DEPTH):0]   ras_count,
    output logic                     ras_empty,
    output logic                     ras_full,
    output logic                     ras_ovf,
    output logic                     ras_unf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        SEL_INC    = 3'b000,
        SEL_HOLD   = 3'b001,
        SEL_BRANCH = 3'b010,
        SEL_JUMP   = 3'b011,
        SEL_CALL   = 3'b100,
        SEL_RET    = 3'b101
    } sel_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [WIDTH-1:0] pc_plus_step;
    logic [PW-1:0]    top_idx;
    logic             push;
    logic             is_full;
    logic             is_empty;

    // Sums are truncated to WIDTH bits, so wrap-around falls out naturally.
    assign pc_plus_step = pc_q + WIDTH'(STEP);
    // The write pointer is a power-of-two-sized counter, so wp-1 wraps mod DEPTH.
    assign top_idx      = wp_q - PW'(1);
    assign is_full      = (count_q == CW'(DEPTH));
    assign is_empty     = (count_q == '0);

    always_comb begin
        pc_d    = pc_q;
        wp_d    = wp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;

        if (en) begin
            // Clear first; any flag set below in the same cycle overrides it.
            if (err_clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end

            case (sel_e'(PC_sel))
                SEL_INC:    pc_d = pc_plus_step;
                SEL_HOLD:   pc_d = pc_q;
                SEL_BRANCH: pc_d = pc_q + PC_branch;
                SEL_JUMP:   pc_d = PC_in;
                SEL_CALL: begin
                    // The push happens even when full and overwrites the oldest
                    // slot, which is the slot wp already points at.
                    push = 1'b1;
                    wp_d = wp_q + PW'(1);
                    pc_d = PC_in;
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                SEL_RET: begin
                    if (is_empty) begin
                        // Underflow: step past the return, leave the pointer alone.
                        unf_d = 1'b1;
                        pc_d  = pc_plus_step;
                    end else begin
                        pc_d    = stack_mem[top_idx];
                        wp_d    = top_idx;
                        count_d = count_q - CW'(1);
                    end
                end
                default:    pc_d = pc_plus_step;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            wp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage has no reset; entries are only read while ras_count says
    // they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wp_q] <= pc_plus_step;
        end
    end

    assign PC_out    = pc_q;
    assign ras_count = count_q;
    assign ras_empty = is_empty;
    assign ras_full  = is_full;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule
